// File: rtl/instruction_byte_fetch_if.sv
// Byte-wide instruction memory port plus the decode-side word handshake.
// The master modport belongs to the fetch unit; the slave modport to its environment.
interface instruction_byte_fetch_if #(
    parameter int unsigned MEM_AW = 12
);
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [31:0]       instr;
    logic [63:0]       instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              pc_src;
    logic [63:0]       branch_addr;
    logic              halted;

    modport master (
        output mem_rd, mem_addr, instr, instr_pc, instr_valid, halted,
        input  mem_rdata, instr_ready, pc_src, branch_addr
    );

    modport slave (
        input  mem_rd, mem_addr, instr, instr_pc, instr_valid, halted,
        output mem_rdata, instr_ready, pc_src, branch_addr
    );
endinterface

// File: rtl/instruction_byte_fetch.sv
// Fetches a 32-bit little-endian instruction one byte per cycle, presents it to
// decode with a valid/ready handshake, and stops for good after a HALT word.
module instruction_byte_fetch #(
    parameter int unsigned MEM_AW   = 12,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic                      clk,
    input logic                      reset_n,
    instruction_byte_fetch_if.master bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        LAST    = 2'd1,
        PRESENT = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_k, w_k_nxt, w_k_inc;
    logic              r_mem_rd, w_mem_rd_nxt;
    logic [MEM_AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [63:0]       r_pc, w_pc_nxt, w_pc_xfer;
    logic [63:0]       r_instr_pc, w_instr_pc_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_halted, w_halted_nxt;
    logic [31:0]       r_instr;
    logic              r_cap_vld;
    logic [1:0]        r_cap_idx;
    logic              w_xfer, w_is_halt;

    assign w_xfer    = (r_state == PRESENT) && bus.instr_ready;
    assign w_is_halt = (r_instr[31:21] == 11'h7FF);
    assign w_k_inc   = r_k + 2'd1;
    assign w_pc_xfer = bus.pc_src ? (bus.branch_addr & ~64'h3) : (r_pc + 64'd4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= FETCH;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (r_mem_rd && (r_k == 2'd3)) w_state_nxt = LAST;
            LAST:    w_state_nxt = PRESENT;
            PRESENT: if (w_xfer) w_state_nxt = w_is_halt ? HALT : FETCH;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    // FETCH with mem_rd low only occurs right after reset: issue byte 0 then.
    always_comb begin
        w_mem_rd_nxt   = 1'b0;
        w_k_nxt        = r_k;
        w_mem_addr_nxt = r_mem_addr;
        w_pc_nxt       = r_pc;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_halted_nxt   = r_halted;
        case (r_state)
            FETCH: begin
                if (!r_mem_rd) begin
                    w_mem_rd_nxt   = 1'b1;
                    w_k_nxt        = 2'd0;
                    w_mem_addr_nxt = r_pc[MEM_AW-1:0];
                end else if (r_k != 2'd3) begin
                    w_mem_rd_nxt   = 1'b1;
                    w_k_nxt        = w_k_inc;
                    w_mem_addr_nxt = r_pc[MEM_AW-1:0] + MEM_AW'(w_k_inc);
                end else begin
                    w_k_nxt = 2'd0;
                end
            end
            LAST: begin
                w_valid_nxt    = 1'b1;
                w_instr_pc_nxt = r_pc;
            end
            PRESENT: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    if (w_is_halt) begin
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_pc_nxt       = w_pc_xfer;
                        w_mem_rd_nxt   = 1'b1;
                        w_k_nxt        = 2'd0;
                        w_mem_addr_nxt = w_pc_xfer[MEM_AW-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // Read data trails mem_rd by one cycle, so the byte lane is delayed to match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k        <= 2'd0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_pc       <= RESET_PC;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_instr    <= 32'hD503201F;
            r_cap_vld  <= 1'b0;
            r_cap_idx  <= 2'd0;
        end else begin
            r_k        <= w_k_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_pc       <= w_pc_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_halted   <= w_halted_nxt;
            r_cap_vld  <= r_mem_rd;
            r_cap_idx  <= r_k;
            if (r_cap_vld) r_instr[{r_cap_idx, 3'b000} +: 8] <= bus.mem_rdata;
        end
    end

    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = r_halted;

endmodule

// File: tb/tb_instruction_byte_fetch.sv
// Scoreboard bench: stimulus queues expected words and addresses, monitors
// compare them against what each fetch unit presents.
`timescale 1ns/1ps
module tb_instruction_byte_fetch;

    typedef struct packed {
        logic [31:0] w;
        logic [63:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    instruction_byte_fetch_if #(.MEM_AW(12)) bus1 ();
    instruction_byte_fetch_if #(.MEM_AW(12)) bus2 ();

    instruction_byte_fetch #(.MEM_AW(12), .RESET_PC(64'h0)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );
    instruction_byte_fetch #(.MEM_AW(12), .RESET_PC(64'hFFE)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    logic [7:0]  mem [0:4095];
    exp_t        q1[$], q2[$];
    logic [11:0] aq1[$], aq2[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, t_rd = 0;
    logic p_rd = 1'b0, p_valid = 1'b0;

    // Memory returns data the cycle after the strobe; 8'hEE marks idle cycles.
    always @(posedge clk) begin
        bus1.mem_rdata <= bus1.mem_rd ? mem[bus1.mem_addr] : 8'hEE;
        bus2.mem_rdata <= bus2.mem_rd ? mem[bus2.mem_addr] : 8'hEE;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push1(input logic [31:0] w, input logic [63:0] pc);
        exp_t e;
        e.w = w; e.pc = pc;
        q1.push_back(e);
        for (int k = 0; k < 4; k++) aq1.push_back(pc[11:0] + 12'(k));
    endtask

    task automatic push2(input logic [31:0] w, input logic [63:0] pc);
        exp_t e;
        e.w = w; e.pc = pc;
        q2.push_back(e);
        for (int k = 0; k < 4; k++) aq2.push_back(pc[11:0] + 12'(k));
    endtask

    always @(negedge clk) begin
        cyc++;
        if (bus1.mem_rd && aq1.size() > 0) chk("addr1", 64'(bus1.mem_addr), 64'(aq1.pop_front()));
        if (bus1.mem_rd && !p_rd) t_rd = cyc;
        if (bus1.instr_valid && !p_valid) chk("latency1", 64'(cyc - t_rd), 64'd5);
        p_rd    = bus1.mem_rd;
        p_valid = bus1.instr_valid;
        if (bus1.instr_valid) begin
            chk("rd_while_valid1", 64'(bus1.mem_rd), 64'd0);
            if (q1.size() > 0) begin
                chk("instr1", 64'(bus1.instr), 64'(q1[0].w));
                chk("instr_pc1", bus1.instr_pc, q1[0].pc);
                if (bus1.instr_ready) void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.mem_rd && aq2.size() > 0) chk("addr2", 64'(bus2.mem_addr), 64'(aq2.pop_front()));
        if (bus2.instr_valid && q2.size() > 0) begin
            chk("instr2", 64'(bus2.instr), 64'(q2[0].w));
            chk("instr_pc2", bus2.instr_pc, q2[0].pc);
            if (bus2.instr_ready) void'(q2.pop_front());
        end
    end

    task automatic check_reset1();
        chk("rst_rd", 64'(bus1.mem_rd), 64'd0);
        chk("rst_addr", 64'(bus1.mem_addr), 64'd0);
        chk("rst_instr", 64'(bus1.instr), 64'hD503201F);
        chk("rst_instr_pc", bus1.instr_pc, 64'd0);
        chk("rst_valid", 64'(bus1.instr_valid), 64'd0);
        chk("rst_halted", 64'(bus1.halted), 64'd0);
    endtask

    // Waits for valid, holds ready low for `hold` cycles while scrambling the
    // branch inputs, then performs one transfer with the given pc_src/branch.
    task automatic xfer(input int hold, input logic src, input logic [63:0] ba);
        bit seen = 1'b0;
        if (hold == 0) begin
            bus1.instr_ready = 1'b1; bus1.pc_src = src; bus1.branch_addr = ba;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus1.instr_valid) seen = 1'b1;
            else if (hold != 0) begin
                bus1.pc_src = ~bus1.pc_src; bus1.branch_addr = {$urandom, $urandom};
            end
        end
        chk("valid_timeout", 64'(seen), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus1.pc_src = ~bus1.pc_src; bus1.branch_addr = {$urandom, $urandom};
        end
        bus1.instr_ready = 1'b1; bus1.pc_src = src; bus1.branch_addr = ba;
        @(posedge clk); #1;
        bus1.instr_ready = 1'b0; bus1.pc_src = ~src; bus1.branch_addr = 64'hDEAD_BEEF_0000_0F00;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]}             = 32'hD503201F;
        {mem[7], mem[6], mem[5], mem[4]}             = 32'h11223344;
        {mem[11], mem[10], mem[9], mem[8]}           = 32'hFFE00000;
        {mem[67], mem[66], mem[65], mem[64]}         = 32'h55667788;
        {mem[259], mem[258], mem[257], mem[256]}     = 32'hA1B2C3D4;
        {mem[263], mem[262], mem[261], mem[260]}     = 32'h0BADF00D;
        mem[4094] = 8'h12;
        mem[4095] = 8'h34;
        bus1.instr_ready = 1'b0; bus1.pc_src = 1'b0; bus1.branch_addr = '0;
        bus2.instr_ready = 1'b0; bus2.pc_src = 1'b0; bus2.branch_addr = '0;

        // Run 1: sequential fetch, stalled handshake, HALT
        #3 reset_n = 1'b0;
        #1 check_reset1();
        push1(32'hD503201F, 64'h0);
        push1(32'h11223344, 64'h4);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("first_rd", 64'(bus1.mem_rd), 64'd1);
        chk("first_addr", 64'(bus1.mem_addr), 64'd0);
        xfer(0, 1'b0, 64'h0);
        push1(32'hFFE00000, 64'h8);
        xfer(7, 1'b0, 64'h0);
        xfer(2, 1'b1, 64'h200);
        chk("halted", 64'(bus1.halted), 64'd1);
        for (int i = 0; i < 22; i++) begin
            bus1.instr_ready = 1'b1; bus1.pc_src = ~bus1.pc_src; bus1.branch_addr = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("halt_quiet", 64'({bus1.mem_rd, bus1.instr_valid, bus1.halted}), 64'd1);
        end
        bus1.instr_ready = 1'b0;

        // Run 2: reset out of HALT, branch, mid-fetch reset
        #2 reset_n = 1'b0;
        #1 check_reset1();
        q1.delete(); aq1.delete();
        push1(32'hD503201F, 64'h0);
        push1(32'hA1B2C3D4, 64'h100);
        @(negedge clk); reset_n = 1'b1;
        xfer(1, 1'b1, 64'h103);
        push1(32'h0BADF00D, 64'h104);
        xfer(3, 1'b0, 64'h0);
        push1(32'h55667788, 64'h40);
        xfer(2, 1'b1, 64'h40);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (bus1.mem_rd && bus1.mem_addr == 12'h042) found = 1'b1;
        end
        chk("reach_byte2", 64'(found), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_reset1();
        q1.delete(); aq1.delete();
        push1(32'hD503201F, 64'h0);
        @(negedge clk); reset_n = 1'b1;
        xfer(0, 1'b0, 64'h0);

        // Run 3: address wrap on the 0xFFE instance
        #2 reset_n = 1'b0;
        #1;
        chk("rst2_rd", 64'(bus2.mem_rd), 64'd0);
        chk("rst2_addr", 64'(bus2.mem_addr), 64'd0);
        chk("rst2_instr_pc", bus2.instr_pc, 64'd0);
        q1.delete(); aq1.delete(); q2.delete(); aq2.delete();
        push2(32'h201F3412, 64'hFFE);
        push2(32'h3344D503, 64'h1002);
        bus2.instr_ready = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("first_rd2", 64'(bus2.mem_rd), 64'd1);
        chk("first_addr2", 64'(bus2.mem_addr), 64'hFFE);
        for (int i = 0; i < 40 && q2.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        bus2.instr_ready = 1'b0;
        chk("q2_drained", 64'(q2.size()), 64'd0);
        chk("aq2_drained", 64'(aq2.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
